// File: rtl/com_pkg.sv
// Shared types and constants for the com control sequencer.
// One-hot state encoding, default block-type codes and the try counter width.
package com_pkg;

    typedef enum logic [9:0] {
        MAIN_IDLE = 10'b00_0000_0001,
        MAIN_WAIT = 10'b00_0000_0010,
        READ_IDLE = 10'b00_0000_0100,
        READ_WAIT = 10'b00_0000_1000,
        READ_WORK = 10'b00_0001_0000,
        READ_DONE = 10'b00_0010_0000,
        SEND_IDLE = 10'b00_0100_0000,
        SEND_WAIT = 10'b00_1000_0000,
        SEND_WORK = 10'b01_0000_0000,
        SEND_DONE = 10'b10_0000_0000
    } state_t;

    localparam int unsigned BTYPE_INIT_DEF = 0;
    localparam int unsigned BTYPE_INFO_DEF = 1;
    localparam int unsigned BTYPE_DATA_DEF = 14;

    function automatic int unsigned try_cnt_w(input int unsigned max_try);
        return (max_try < 1) ? 1 : $clog2(max_try + 1);
    endfunction

endpackage

// File: rtl/com_timer.sv
// Per-state window counter: runs while en is high, restarts from 0 whenever en drops.
// expire is high during the LIMIT-th consecutive enabled cycle.
module com_timer #(
    parameter int unsigned LIMIT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic expire
);

    localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    // Saturate at LAST so a stalled state cannot wrap into a second expiry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expire = en && (cnt == LAST);

endmodule

// File: rtl/com_cs_ctrl.sv
// Sequencer between the collect-side data path and the com link layer:
// arbitrates send/read, drives the link handshakes and retries unanswered sends.
module com_cs_ctrl
    import com_pkg::*;
#(
    parameter int unsigned BTYPE_W    = 4,
    parameter int unsigned IDX_W      = 4,
    parameter int unsigned IDX_MAX    = 5,
    parameter int unsigned TIMEOUT    = 450,
    parameter int unsigned RD_TIMEOUT = 1024,
    parameter int unsigned MAX_TRY    = 3,
    parameter logic [BTYPE_W-1:0] BTYPE_INIT = BTYPE_W'(BTYPE_INIT_DEF),
    parameter logic [BTYPE_W-1:0] BTYPE_INFO = BTYPE_W'(BTYPE_INFO_DEF),
    parameter logic [BTYPE_W-1:0] BTYPE_DATA = BTYPE_W'(BTYPE_DATA_DEF)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           fs_send,
    output logic                           fd_send,
    output logic                           send_ok,
    output logic                           fs_read,
    input  logic                           fd_read,
    output logic                           rd_timeout,
    output logic                           fs_com_send,
    input  logic                           fd_com_send,
    input  logic                           fs_com_read,
    output logic                           fd_com_read,
    output logic [BTYPE_W-1:0]             com_tx_btype,
    input  logic [BTYPE_W-1:0]             com_rx_btype,
    output logic [BTYPE_W-1:0]             com_btype,
    output logic [IDX_W-1:0]               data_idx,
    output logic [try_cnt_w(MAX_TRY)-1:0]  try_cnt
);

    localparam int unsigned TRY_W = try_cnt_w(MAX_TRY);

    state_t state, state_nxt;

    logic snd_exp, rd_exp;
    logic snd_acc, rd_acc, snd_rsp, snd_tmo, snd_last;

    com_timer #(.LIMIT(TIMEOUT)) u_send_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (state == SEND_WAIT),
        .expire (snd_exp)
    );

    com_timer #(.LIMIT(RD_TIMEOUT)) u_read_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (state == READ_WAIT),
        .expire (rd_exp)
    );

    // A response or upstream consume on the expiry cycle takes precedence over the timeout.
    assign rd_acc     = (state == MAIN_WAIT) && fs_com_read;
    assign snd_acc    = (state == MAIN_WAIT) && !fs_com_read && fs_send;
    assign snd_rsp    = (state == SEND_WAIT) && fs_com_read;
    assign snd_tmo    = snd_exp && !fs_com_read;
    assign snd_last   = (try_cnt == TRY_W'(MAX_TRY - 1));
    assign rd_timeout = rd_exp && !fd_read;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= MAIN_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MAIN_IDLE: state_nxt = MAIN_WAIT;
            MAIN_WAIT: begin
                if (fs_com_read) begin
                    state_nxt = READ_IDLE;
                end else if (fs_send) begin
                    state_nxt = SEND_IDLE;
                end
            end
            READ_IDLE: state_nxt = READ_WAIT;
            READ_WAIT: begin
                if (fd_read) begin
                    state_nxt = READ_WORK;
                end else if (rd_exp) begin
                    state_nxt = READ_DONE;
                end
            end
            READ_WORK: if (!fs_com_read) state_nxt = READ_DONE;
            READ_DONE: if (fd_com_send) state_nxt = MAIN_WAIT;
            SEND_IDLE: if (fd_com_send) state_nxt = SEND_WAIT;
            SEND_WAIT: begin
                if (fs_com_read) begin
                    state_nxt = SEND_WORK;
                end else if (snd_exp) begin
                    state_nxt = snd_last ? SEND_DONE : SEND_IDLE;
                end
            end
            SEND_WORK: if (!fs_com_read) state_nxt = SEND_DONE;
            SEND_DONE: if (!fs_send) state_nxt = MAIN_IDLE;
            default:   state_nxt = MAIN_IDLE;
        endcase
    end

    assign fd_send     = (state == SEND_DONE);
    assign fs_read     = (state == READ_WAIT);
    assign fs_com_send = (state == SEND_IDLE) || (state == READ_DONE);
    assign fd_com_read = (state == SEND_WORK) || (state == READ_WORK);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_idx <= IDX_W'(IDX_MAX);
        end else if (snd_acc) begin
            data_idx <= (data_idx == IDX_W'(IDX_MAX)) ? '0 : data_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            com_tx_btype <= BTYPE_INIT;
        end else if (state == MAIN_IDLE) begin
            com_tx_btype <= BTYPE_INIT;
        end else if (snd_acc) begin
            com_tx_btype <= BTYPE_DATA;
        end else if (rd_acc) begin
            com_tx_btype <= BTYPE_INFO;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            com_btype <= BTYPE_INIT;
        end else if ((state == MAIN_IDLE) || (state == MAIN_WAIT)) begin
            com_btype <= BTYPE_INIT;
        end else if ((state == READ_IDLE) || snd_rsp) begin
            com_btype <= com_rx_btype;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            try_cnt <= '0;
            send_ok <= 1'b0;
        end else if ((state == MAIN_IDLE) || snd_acc) begin
            try_cnt <= '0;
            send_ok <= 1'b0;
        end else if (snd_rsp) begin
            send_ok <= 1'b1;
        end else if (snd_tmo) begin
            if (snd_last) begin
                send_ok <= 1'b0;
            end else begin
                try_cnt <= try_cnt + TRY_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_com_cs_ctrl.sv
// Randomised transaction-level bench for com_cs_ctrl: per-transaction outcomes
// (tries, gaps, status, indices, types) are predicted arithmetically and compared.
module tb_com_cs_ctrl;
    import com_pkg::*;

    localparam int BW   = 4;
    localparam int IW   = 4;
    localparam int IMAX = 5;
    localparam int TO   = 8;
    localparam int RTO  = 16;
    localparam int MT   = 3;
    localparam int TW   = try_cnt_w(MT);
    localparam logic [BW-1:0] B_INIT = 4'd0;
    localparam logic [BW-1:0] B_INFO = 4'd1;
    localparam logic [BW-1:0] B_DATA = 4'd14;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fs_send = 1'b0;
    logic          fd_read = 1'b0;
    logic          fd_com_send = 1'b0;
    logic          fs_com_read = 1'b0;
    logic [BW-1:0] com_rx_btype = '0;
    logic          fd_send, send_ok, fs_read, rd_timeout, fs_com_send, fd_com_read;
    logic [BW-1:0] com_tx_btype, com_btype;
    logic [IW-1:0] data_idx;
    logic [TW-1:0] try_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_idx = IMAX;

    com_cs_ctrl #(
        .BTYPE_W   (BW),
        .IDX_W     (IW),
        .IDX_MAX   (IMAX),
        .TIMEOUT   (TO),
        .RD_TIMEOUT(RTO),
        .MAX_TRY   (MT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fs_send     (fs_send),
        .fd_send     (fd_send),
        .send_ok     (send_ok),
        .fs_read     (fs_read),
        .fd_read     (fd_read),
        .rd_timeout  (rd_timeout),
        .fs_com_send (fs_com_send),
        .fd_com_send (fd_com_send),
        .fs_com_read (fs_com_read),
        .fd_com_read (fd_com_read),
        .com_tx_btype(com_tx_btype),
        .com_rx_btype(com_rx_btype),
        .com_btype   (com_btype),
        .data_idx    (data_idx),
        .try_cnt     (try_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_reset_vals();
        chk("rst_fd_send", fd_send, 0);
        chk("rst_send_ok", send_ok, 0);
        chk("rst_fs_read", fs_read, 0);
        chk("rst_rd_tmo", rd_timeout, 0);
        chk("rst_fs_com_send", fs_com_send, 0);
        chk("rst_fd_com_read", fd_com_read, 0);
        chk("rst_tx_btype", com_tx_btype, B_INIT);
        chk("rst_btype", com_btype, B_INIT);
        chk("rst_idx", data_idx, IMAX);
        chk("rst_try", try_cnt, 0);
    endtask

    // resp_try: index of the try that gets answered (>= MT means never).
    task automatic do_send(input int resp_try, input int resp_delay, input logic [BW-1:0] rx);
        int  t_fd, n, n_tx, exp_tries;
        bit  ok;
        ok = (resp_try < MT);
        exp_tries = ok ? resp_try + 1 : MT;
        exp_idx = (exp_idx + 1) % (IMAX + 1);
        t_fd = 0;
        n_tx = 0;
        fs_send = 1'b1;
        step();
        chk("snd_latency", fs_com_send, 1);
        chk("snd_tx_data", com_tx_btype, B_DATA);
        chk("snd_idx", data_idx, exp_idx);
        for (int t = 0; t < MT; t++) begin
            n = 0;
            while (!fs_com_send && n < 50) begin
                step();
                n++;
            end
            if (!fs_com_send) begin
                chk("snd_wait_bound", 0, 1);
                fs_send = 1'b0;
                return;
            end
            if (t > 0) chk("retry_gap", cyc - t_fd, TO + 1);
            n_tx++;
            chk("try_at_tx", try_cnt, t);
            repeat ($urandom_range(0, 3)) step();
            fd_com_send = 1'b1;
            t_fd = cyc;
            step();
            fd_com_send = 1'b0;
            if (t == resp_try) begin
                repeat (resp_delay) step();
                fs_com_read = 1'b1;
                com_rx_btype = rx;
                step();
                chk("snd_fd_com_read", fd_com_read, 1);
                chk("snd_rx_btype", com_btype, rx);
                fs_com_read = 1'b0;
                com_rx_btype = BW'($urandom);
                step();
                break;
            end
        end
        if (!ok) begin
            n = 0;
            while (!fd_send && n < 50) begin
                step();
                n++;
            end
            chk("final_gap", cyc - t_fd, TO + 1);
        end
        chk("fd_send", fd_send, 1);
        chk("n_tx", n_tx, exp_tries);
        chk("send_ok", send_ok, ok);
        chk("try_done", try_cnt, exp_tries - 1);
        chk("done_btype", com_btype, ok ? rx : B_INIT);
        chk("done_idx", data_idx, exp_idx);
        repeat ($urandom_range(0, 2)) begin
            step();
            chk("fd_hold", fd_send, 1);
            chk("ok_hold", send_ok, ok);
        end
        fs_send = 1'b0;
        step();
        chk("fd_drop", fd_send, 0);
        step();
        chk("idle_tx_btype", com_tx_btype, B_INIT);
        chk("idle_try", try_cnt, 0);
        chk("idle_ok", send_ok, 0);
    endtask

    // fd_delay < 0: upstream never consumes, the watchdog must fire.
    task automatic do_read(input logic [BW-1:0] rx, input int fd_delay, input bit with_send);
        fs_com_read = 1'b1;
        com_rx_btype = rx;
        if (with_send) fs_send = 1'b1;
        step();
        chk("rd_priority", fs_com_send, 0);
        chk("rd_tx_info", com_tx_btype, B_INFO);
        chk("rd_idx", data_idx, exp_idx);
        step();
        chk("fs_read", fs_read, 1);
        chk("rd_btype", com_btype, rx);
        com_rx_btype = BW'($urandom);
        if (fd_delay >= 0) begin
            repeat (fd_delay) begin
                chk("rd_tmo_early", rd_timeout, 0);
                step();
            end
            fd_read = 1'b1;
            #1;
            chk("rd_tmo_resp", rd_timeout, 0);
            step();
            fd_read = 1'b0;
            chk("rd_fd_com_read", fd_com_read, 1);
            chk("rd_btype_hold", com_btype, rx);
            fs_com_read = 1'b0;
            step();
        end else begin
            for (int i = 1; i <= RTO; i++) begin
                chk("rd_tmo_pulse", rd_timeout, int'(i == RTO));
                step();
            end
            fs_com_read = 1'b0;
        end
        chk("rd_done_send", fs_com_send, 1);
        chk("rd_done_fs_read", fs_read, 0);
        repeat ($urandom_range(0, 2)) step();
        fd_com_send = 1'b1;
        step();
        fd_com_send = 1'b0;
        chk("rd_back_idle", fs_com_send | fd_com_read | fs_read, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog_time_limit");
        $fatal(1);
    end

    initial begin
        int kind, fdl;
        repeat (2) step();
        chk_reset_vals();
        rst_n = 1'b1;
        step();

        do_send(0, 5, 4'h2);
        do_send(MT, 0, 4'h0);
        do_read(4'h3, 2, 1'b1);
        do_send(0, 1, 4'h7);
        do_read(4'h4, -1, 1'b0);
        do_send(0, TO - 1, 4'h9);
        do_send(MT - 1, TO - 1, 4'hA);
        do_read(4'h5, RTO - 1, 1'b0);

        fs_send = 1'b1;
        step();
        fd_com_send = 1'b1;
        step();
        fd_com_send = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        fs_send = 1'b0;
        chk_reset_vals();
        exp_idx = IMAX;
        rst_n = 1'b1;
        step();
        step();

        for (int k = 0; k < 40; k++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                do_send($urandom_range(0, MT), $urandom_range(0, TO - 1), BW'($urandom));
            end else begin
                fdl = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, RTO - 1);
                do_read(BW'($urandom), fdl, kind == 2);
                if (kind == 2) begin
                    do_send($urandom_range(0, MT), $urandom_range(0, TO - 1), BW'($urandom));
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
